// File: rtl/iir_biquad_cascade_if.sv
// rtl/iir_biquad_cascade_if.sv - sample stream and coefficient bus bundle for iir_biquad_cascade
//
// Signals:
//   in_valid/in_ready/din     sample set into the filter, channel 0 in LSBs
//   dout/out_valid            filtered sample set, out_valid pulses once per result
//   coef_we/addr/data/commit  shadow coefficient bank write port and commit strobe
//   bypass                    route din to dout and clear section state
// Modports: master drives samples/coefficients, slave is the filter.
interface iir_biquad_cascade_if #(
    parameter int CHANNELS = 2,
    parameter int DW       = 16,
    parameter int CW       = 24
);
    logic                     in_valid;
    logic                     in_ready;
    logic [CHANNELS*DW-1:0]   din;
    logic [CHANNELS*DW-1:0]   dout;
    logic                     out_valid;
    logic                     coef_we;
    logic [7:0]               coef_addr;
    logic [CW-1:0]            coef_data;
    logic                     coef_commit;
    logic                     bypass;

    modport master (
        output in_valid, din, coef_we, coef_addr, coef_data, coef_commit, bypass,
        input  in_ready, dout, out_valid
    );

    modport slave (
        input  in_valid, din, coef_we, coef_addr, coef_data, coef_commit, bypass,
        output in_ready, dout, out_valid
    );
endinterface

// File: rtl/iir_biquad_cascade.sv
// rtl/iir_biquad_cascade.sv - time-multiplexed Direct Form I biquad cascade
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    iir_biquad_cascade_if.slave: sample handshake, result, coefficient bus, bypass
// One section (channel, stage) is evaluated per clock, channel-major. The cycle
// after the last section publishes dout and pulses out_valid, so the latency from
// accept to out_valid is CHANNELS*STAGES+1 cycles.
module iir_biquad_cascade #(
    parameter int CHANNELS = 2,
    parameter int STAGES   = 2,
    parameter int DW       = 16,
    parameter int CW       = 24,
    parameter int AW       = DW + CW + 3
) (
    input  logic                  clk,
    input  logic                  reset,
    iir_biquad_cascade_if.slave   bus
);

    localparam int NCOEF = STAGES * 5;
    localparam int NSEC  = CHANNELS * STAGES;
    localparam int CHW   = $clog2(CHANNELS + 1);
    localparam int STW   = $clog2(STAGES + 1);

    localparam logic signed [CW-1:0] COEF_ONE = {2'b01, {(CW-2){1'b0}}};
    localparam logic signed [AW-1:0] RND_HALF = {{(AW-CW+2){1'b0}}, 1'b1, {(CW-3){1'b0}}};
    localparam logic signed [AW-1:0] SAT_MAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                  state_q, state_d;
    logic [CHW-1:0]          ch_q, ch_d;
    logic [STW-1:0]          st_q, st_d;
    logic [CHANNELS*DW-1:0]  din_q, din_d;
    logic [CHANNELS*DW-1:0]  dout_q, dout_d;
    logic                    byp_q, byp_d;
    logic                    out_valid_q, out_valid_d;
    logic                    commit_pending_q, commit_pending_d;
    logic signed [DW-1:0]    carry_q, carry_d;
    logic signed [DW-1:0]    res_q [CHANNELS];
    logic signed [DW-1:0]    res_d [CHANNELS];
    logic signed [CW-1:0]    shadow_q [NCOEF];
    logic signed [CW-1:0]    shadow_d [NCOEF];
    logic signed [CW-1:0]    active_q [NCOEF];
    logic signed [CW-1:0]    active_d [NCOEF];
    logic signed [DW-1:0]    x1_q [NSEC];
    logic signed [DW-1:0]    x1_d [NSEC];
    logic signed [DW-1:0]    x2_q [NSEC];
    logic signed [DW-1:0]    x2_d [NSEC];
    logic signed [DW-1:0]    y1_q [NSEC];
    logic signed [DW-1:0]    y1_d [NSEC];
    logic signed [DW-1:0]    y2_q [NSEC];
    logic signed [DW-1:0]    y2_d [NSEC];

    // Full-precision product, sign-extended to the accumulator width.
    function automatic logic signed [AW-1:0] mul(input logic signed [DW-1:0] a,
                                                 input logic signed [CW-1:0] b);
        logic signed [DW+CW-1:0] p;
        p = $signed({{CW{a[DW-1]}}, a}) * $signed({{DW{b[CW-1]}}, b});
        return {{(AW-DW-CW){p[DW+CW-1]}}, p};
    endfunction

    // Section datapath for the (ch_q, st_q) currently being evaluated.
    logic                  eval;
    int                    sec;
    logic signed [DW-1:0]  din_ch, x_in, cx1, cx2, cy1, cy2, y_sat;
    logic signed [CW-1:0]  cb0, cb1, cb2, ca1, ca2;
    logic signed [AW-1:0]  acc, rnd, shf;

    always_comb begin
        eval = (state_q == S_RUN) && (int'(ch_q) < CHANNELS);
        sec  = int'(ch_q) * STAGES + int'(st_q);

        din_ch = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(ch_q) == c) din_ch = din_q[c*DW +: DW];
        end
        // Stage 0 takes the latched input; later stages take the previous stage's output.
        x_in = (st_q == '0) ? din_ch : carry_q;

        cx1 = '0; cx2 = '0; cy1 = '0; cy2 = '0;
        for (int i = 0; i < NSEC; i++) begin
            if (i == sec) begin
                cx1 = x1_q[i];
                cx2 = x2_q[i];
                cy1 = y1_q[i];
                cy2 = y2_q[i];
            end
        end

        cb0 = '0; cb1 = '0; cb2 = '0; ca1 = '0; ca2 = '0;
        for (int s = 0; s < STAGES; s++) begin
            if (int'(st_q) == s) begin
                cb0 = active_q[s*5 + 0];
                cb1 = active_q[s*5 + 1];
                cb2 = active_q[s*5 + 2];
                ca1 = active_q[s*5 + 3];
                ca2 = active_q[s*5 + 4];
            end
        end

        acc = mul(x_in, cb0) + mul(cx1, cb1) + mul(cx2, cb2) - mul(cy1, ca1) - mul(cy2, ca2);
        rnd = acc + RND_HALF;
        shf = rnd >>> (CW - 2);

        if (shf > SAT_MAX) begin
            y_sat = {1'b0, {(DW-1){1'b1}}};
        end else if (shf < SAT_MIN) begin
            y_sat = {1'b1, {(DW-1){1'b0}}};
        end else begin
            y_sat = shf[DW-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        st_d        = st_q;
        din_d       = din_q;
        dout_d      = dout_q;
        byp_d       = byp_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        res_d       = res_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        x1_d        = x1_q;
        x2_d        = x2_q;
        y1_d        = y1_q;
        y2_d        = y2_q;

        for (int i = 0; i < NCOEF; i++) begin
            if (bus.coef_we && (int'(bus.coef_addr) == i)) shadow_d[i] = bus.coef_data;
        end
        commit_pending_d = commit_pending_q | bus.coef_commit;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    din_d   = bus.din;
                    byp_d   = bus.bypass;
                    ch_d    = '0;
                    st_d    = '0;
                    state_d = S_RUN;
                    // shadow_d so a write or commit in this same cycle is included.
                    if (commit_pending_d) begin
                        active_d         = shadow_d;
                        commit_pending_d = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (!eval) begin
                    for (int c = 0; c < CHANNELS; c++) dout_d[c*DW +: DW] = res_q[c];
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    for (int i = 0; i < NSEC; i++) begin
                        if (i == sec) begin
                            if (byp_q) begin
                                x1_d[i] = '0;
                                x2_d[i] = '0;
                                y1_d[i] = '0;
                                y2_d[i] = '0;
                            end else begin
                                x2_d[i] = cx1;
                                x1_d[i] = x_in;
                                y2_d[i] = cy1;
                                y1_d[i] = y_sat;
                            end
                        end
                    end
                    carry_d = y_sat;
                    if (int'(st_q) == STAGES - 1) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            if (int'(ch_q) == c) res_d[c] = byp_q ? din_ch : y_sat;
                        end
                        st_d = '0;
                        ch_d = ch_q + CHW'(1);
                    end else begin
                        st_d = st_q + STW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            ch_q             <= '0;
            st_q             <= '0;
            din_q            <= '0;
            dout_q           <= '0;
            byp_q            <= 1'b0;
            out_valid_q      <= 1'b0;
            commit_pending_q <= 1'b0;
            carry_q          <= '0;
            for (int c = 0; c < CHANNELS; c++) res_q[c] <= '0;
            for (int i = 0; i < NCOEF; i++) begin
                shadow_q[i] <= ((i % 5) == 0) ? COEF_ONE : '0;
                active_q[i] <= ((i % 5) == 0) ? COEF_ONE : '0;
            end
            for (int i = 0; i < NSEC; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            ch_q             <= ch_d;
            st_q             <= st_d;
            din_q            <= din_d;
            dout_q           <= dout_d;
            byp_q            <= byp_d;
            out_valid_q      <= out_valid_d;
            commit_pending_q <= commit_pending_d;
            carry_q          <= carry_d;
            res_q            <= res_d;
            shadow_q         <= shadow_d;
            active_q         <= active_d;
            x1_q             <= x1_d;
            x2_q             <= x2_d;
            y1_q             <= y1_d;
            y2_q             <= y2_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.dout      = dout_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb/tb_iir_biquad_cascade.sv - self-checking bench for iir_biquad_cascade
module tb_iir_biquad_cascade;

    localparam int CH  = 2;
    localparam int ST  = 2;
    localparam int DW  = 16;
    localparam int CW  = 24;
    localparam int NC  = ST * 5;
    localparam int LAT = CH * ST + 1;

    logic clk;
    logic reset;

    iir_biquad_cascade_if #(.CHANNELS(CH), .DW(DW), .CW(CW)) bus ();

    iir_biquad_cascade #(.CHANNELS(CH), .STAGES(ST), .DW(DW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: coefficient banks and per-channel, per-stage history.
    logic [CW-1:0] mshadow [NC];
    logic [CW-1:0] mactive [NC];
    bit            mpending;
    longint        mx1 [CH][ST];
    longint        mx2 [CH][ST];
    longint        my1 [CH][ST];
    longint        my2 [CH][ST];

    function automatic longint cv(input int i);
        return longint'($signed(mactive[i]));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            mshadow[i] = (i % 5 == 0) ? 24'h400000 : 24'h0;
            mactive[i] = mshadow[i];
        end
        mpending = 0;
        for (int c = 0; c < CH; c++)
            for (int s = 0; s < ST; s++) begin
                mx1[c][s] = 0; mx2[c][s] = 0; my1[c][s] = 0; my2[c][s] = 0;
            end
    endtask

    function automatic logic [CH*DW-1:0] model_accept(input logic [CH*DW-1:0] d, input bit byp);
        logic [CH*DW-1:0] r;
        longint x, y, acc;
        if (mpending) begin
            mactive  = mshadow;
            mpending = 0;
        end
        r = '0;
        for (int c = 0; c < CH; c++) begin
            x = longint'($signed(d[c*DW +: DW]));
            for (int s = 0; s < ST; s++) begin
                if (byp) begin
                    mx1[c][s] = 0; mx2[c][s] = 0; my1[c][s] = 0; my2[c][s] = 0;
                end else begin
                    acc = cv(s*5) * x + cv(s*5+1) * mx1[c][s] + cv(s*5+2) * mx2[c][s]
                        - cv(s*5+3) * my1[c][s] - cv(s*5+4) * my2[c][s];
                    y = (acc + (64'sd1 <<< (CW-3))) >>> (CW-2);
                    if (y > 32767)  y = 32767;
                    if (y < -32768) y = -32768;
                    mx2[c][s] = mx1[c][s];
                    mx1[c][s] = x;
                    my2[c][s] = my1[c][s];
                    my1[c][s] = y;
                    x = y;
                end
            end
            r[c*DW +: DW] = byp ? d[c*DW +: DW] : x[DW-1:0];
        end
        return r;
    endfunction

    task automatic wr(input int addr, input logic [CW-1:0] data);
        @(negedge clk);
        bus.coef_we   = 1'b1;
        bus.coef_addr = 8'(addr);
        bus.coef_data = data;
        @(posedge clk);
        if (addr < NC) mshadow[addr] = data;
        #1 bus.coef_we = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk);
        bus.coef_commit = 1'b1;
        @(posedge clk);
        mpending = 1;
        #1 bus.coef_commit = 1'b0;
    endtask

    // Send one sample set, then check latency, model result and optional literal.
    task automatic send(input logic [CH*DW-1:0] d, input bit byp, input bit cmt,
                        input bit use_lit, input logic [CH*DW-1:0] lit);
        logic [CH*DW-1:0] exp;
        int cnt;
        bit got;
        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid    = 1'b1;
        bus.din         = d;
        bus.bypass      = byp;
        bus.coef_commit = cmt;
        @(posedge clk);
        if (cmt) mpending = 1;
        exp = model_accept(d, byp);
        #1;
        bus.in_valid    = 1'b0;
        bus.bypass      = 1'b0;
        bus.coef_commit = 1'b0;
        check("in_ready_run", bus.in_ready, 0);
        cnt = 0;
        got = 0;
        while (cnt < 40 && !got) begin
            @(posedge clk);
            #1;
            cnt++;
            if (bus.out_valid) got = 1;
        end
        check("latency", cnt, LAT);
        check("dout_model", bus.dout, exp);
        if (use_lit) check("dout_lit", bus.dout, lit);
        @(posedge clk);
        #1 check("out_valid_pulse", bus.out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CH*DW-1:0] d;
        logic [CW-1:0]    cd;
        logic [19:0]      r20;
        bit               seen;

        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.din         = '0;
        bus.coef_we     = 1'b0;
        bus.coef_addr   = '0;
        bus.coef_data   = '0;
        bus.coef_commit = 1'b0;
        bus.bypass      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_dout", bus.dout, 0);
        reset = 1'b0;

        // Passthrough after reset
        send(32'hEDCC1234, 0, 0, 1, 32'hEDCC1234);

        // Gain 0.5 on stage 0, stage 1 untouched
        wr(0, 24'h200000);
        commit();
        send(32'h40004000, 0, 0, 1, 32'h20002000);

        // Saturation both directions
        wr(0, 24'h7FFFFF);
        commit();
        send(32'h90007000, 0, 0, 1, 32'h80007FFF);

        // Bypass clears all state and returns din
        send(32'hABCD0123, 1, 0, 1, 32'hABCD0123);

        // Recursion: a1 = -0.5; commit in the accept cycle of the first step sample
        wr(0, 24'h400000);
        wr(3, 24'hE00000);
        send(32'h10001000, 0, 1, 1, 32'h10001000);
        send(32'h10001000, 0, 0, 1, 32'h18001800);
        send(32'h10001000, 0, 0, 1, 32'h1C001C00);
        send(32'h10001000, 0, 0, 1, 32'h1E001E00);

        // Shadow write during RUN without commit has no effect
        fork
            send(32'h10001000, 0, 0, 1, 32'h1F001F00);
            begin
                repeat (2) @(negedge clk);
                wr(0, 24'h200000);
            end
        join
        send(32'h10001000, 0, 0, 1, 32'h1F801F80);
        commit();
        send(32'h10001000, 0, 0, 1, 32'h17C017C0);
        send(32'h10001000, 0, 0, 1, 32'h13E013E0);

        // Reset two cycles after accept
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.din      = 32'h55552222;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrun_in_ready", bus.in_ready, 1);
        check("midrun_dout", bus.dout, 0);
        check("midrun_out_valid", bus.out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (bus.out_valid) seen = 1;
        end
        check("midrun_no_out_valid", seen, 0);
        wr(3, 24'hE00000);
        commit();
        send(32'h10001000, 0, 0, 1, 32'h10001000);
        send(32'h00000000, 0, 0, 1, 32'h08000800);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                r20 = 20'($urandom);
                if ($urandom_range(0, 1) == 1) cd = 24'($urandom);
                else cd = {{4{r20[19]}}, r20};
                wr(int'($urandom_range(0, NC + 2)), cd);
            end
            if ($urandom_range(0, 2) == 0) commit();
            d = 32'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                r20 = 20'($urandom);
                fork
                    send(d, 0, 0, 0, '0);
                    begin
                        repeat (2) @(negedge clk);
                        wr(int'($urandom_range(0, NC - 1)), {{4{r20[19]}}, r20});
                        commit();
                    end
                join
            end else begin
                send(d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 0, '0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
